// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and digit-validity helper for the serial
// and parallel BCD adder paths.
package bcd_pkg;

  localparam int          DIGIT_W  = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [4:0]  BCD_CORR = 5'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle of the digit-serial BCD adder: start/busy/done handshake,
// packed BCD operands and held result.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, invalid
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, invalid
  );
endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder; digits above 9 follow the same
// correction rule, so the output is always defined.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] da_i,
  input  logic [DIGIT_W-1:0] db_i,
  input  logic               cin_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               cout_o
);

  logic [4:0] raw_sum;
  logic [4:0] corr_sum;

  always_comb begin
    raw_sum  = {1'b0, da_i} + {1'b0, db_i} + {4'd0, cin_i};
    corr_sum = raw_sum + BCD_CORR;
    if (raw_sum > {1'b0, BCD_MAX}) begin
      digit_o = corr_sum[DIGIT_W-1:0];
      cout_o  = 1'b1;
    end else begin
      digit_o = raw_sum[DIGIT_W-1:0];
      cout_o  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per clock LSD first, done DIGITS+1 cycles
// after start; start is ignored while busy or done, result held until next done.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_adder_if.slave   bus
);

  localparam int              W    = DIGIT_W * DIGITS;
  localparam int              CW   = $clog2(DIGITS + 1);
  localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            inv_pend_q, inv_pend_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            invalid_q, invalid_d;

  logic [DIGIT_W-1:0] dig;
  logic               dig_c;
  logic               inv_cap;
  logic [W+DIGIT_W-1:0] acc_cat;

  bcd_digit_adder u_digit (
    .da_i    (a_q[DIGIT_W-1:0]),
    .db_i    (b_q[DIGIT_W-1:0]),
    .cin_i   (carry_q),
    .digit_o (dig),
    .cout_o  (dig_c)
  );

  always_comb begin
    inv_cap = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      inv_cap = inv_cap | digit_invalid(bus.a[DIGIT_W*i +: DIGIT_W])
                        | digit_invalid(bus.b[DIGIT_W*i +: DIGIT_W]);
    end
  end

  // New digit enters at the MSD end so after DIGITS shifts digit 0 sits at [3:0].
  assign acc_cat = {dig, acc_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    inv_pend_d = inv_pend_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    invalid_d  = invalid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.cin;
          inv_pend_d = inv_cap;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        carry_d = dig_c;
        acc_d   = acc_cat[W+DIGIT_W-1:DIGIT_W];
        cnt_d   = cnt_q + CW'(1);
        // Result registers load on the last digit so they are visible with done.
        if (cnt_q == LAST) begin
          sum_d     = acc_cat[W+DIGIT_W-1:DIGIT_W];
          cout_d    = dig_c;
          invalid_d = inv_pend_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      inv_pend_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      inv_pend_q <= inv_pend_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      invalid_q  <= invalid_d;
    end
  end

  assign bus.busy    = (state_q == ADD);
  assign bus.done    = (state_q == DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed scenarios plus random
// operands against a digit-wise decimal reference model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digit addition, decimal carry; a digit above 9 gets the
  // same "+6, keep low nibble, carry 1" treatment whenever the column exceeds 9.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, output logic [W-1:0] s,
                                  output logic co, output logic inv);
    int c;
    int col;
    c   = int'(cin);
    s   = '0;
    inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int da, db;
      da  = int'(a[4*i +: 4]);
      db  = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) inv = 1'b1;
      col = da + db + c;
      if (col > 9) begin
        s[4*i +: 4] = 4'((col + 6) % 16);
        c = 1;
      end else begin
        s[4*i +: 4] = 4'(col);
        c = 0;
      end
    end
    co = (c != 0);
  endfunction

  // Drives one start pulse and checks latency, busy window and result.
  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
    logic [W-1:0] es;
    logic         ec, ei;
    int           lat;
    ref_add(a, b, cin, es, ec, ei);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.cin = $urandom_range(0, 1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, lat, bus.busy);
      end
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != DIGITS + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, DIGITS + 1);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.sum !== es || bus.cout !== ec || bus.invalid !== ei) begin
      bad++;
      $display("FAIL %s result: busy=%b sum=%h cout=%b inv=%b want busy=0 sum=%h cout=%b inv=%b",
               name, bus.busy, bus.sum, bus.cout, bus.invalid, es, ec, ei);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== es || bus.cout !== ec) begin
      bad++;
      $display("FAIL %s after done: done=%b busy=%b sum=%h cout=%b want 0 0 %h %b",
               name, bus.done, bus.busy, bus.sum, bus.cout, es, ec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 ||
        bus.cout !== 1'b0 || bus.invalid !== 1'b0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b inv=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.invalid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op("basic_1234_5678", 16'h1234, 16'h5678, 1'b0);
    total++;
    if (bus.sum !== 16'h6912) begin
      bad++;
      $display("FAIL basic literal: got %h want 6912", bus.sum);
    end
  endtask

  task automatic test_ripple();
    run_op("ripple_9999_0001", 16'h9999, 16'h0001, 1'b0);
    total++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
      bad++;
      $display("FAIL ripple literal: got %h/%b want 0000/1", bus.sum, bus.cout);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_max", 16'h9999, 16'h9999, 1'b1);
    total++;
    if (bus.sum !== 16'h9999 || bus.cout !== 1'b1) begin
      bad++;
      $display("FAIL b2b max literal: got %h/%b want 9999/1", bus.sum, bus.cout);
    end
    run_op("b2b_zero", 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 2 || cyc == 5);
      bus.a = 16'h4444; bus.b = 16'h3333; bus.cin = 1'b1;
      if (bus.done === 1'b1) dones++;
      if (cyc == 5) begin
        total++;
        if (bus.done !== 1'b1 || bus.sum !== 16'h0010) begin
          bad++;
          $display("FAIL ignore_start at done: done=%b sum=%h want 1 0010", bus.done, bus.sum);
        end
      end
    end
    bus.start = 1'b0;
    total++;
    if (dones != 1 || bus.sum !== 16'h0010) begin
      bad++;
      $display("FAIL ignore_start pulses: dones=%0d sum=%h want 1 0010", dones, bus.sum);
    end
  endtask

  task automatic test_reset_mid_add();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 ||
        bus.cout !== 1'b0 || bus.invalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_add: busy=%b done=%b sum=%h cout=%b inv=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.invalid);
    end
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_mid_add activity: got %0d busy/done cycles want 0", dones);
    end
    run_op("post_reset_42_58", 16'h0042, 16'h0058, 1'b0);
    total++;
    if (bus.sum !== 16'h0100) begin
      bad++;
      $display("FAIL post_reset literal: got %h want 0100", bus.sum);
    end
  endtask

  task automatic test_invalid();
    run_op("invalid_00A0", 16'h00A0, 16'h0000, 1'b0);
    total++;
    if (bus.invalid !== 1'b1 || bus.sum !== 16'h0100 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL invalid literal: inv=%b sum=%h cout=%b want 1 0100 0",
               bus.invalid, bus.sum, bus.cout);
    end
    run_op("valid_after_invalid", 16'h0001, 16'h0001, 1'b0);
    total++;
    if (bus.invalid !== 1'b0 || bus.sum !== 16'h0002) begin
      bad++;
      $display("FAIL invalid clear: inv=%b sum=%h want 0 0002", bus.invalid, bus.sum);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 40; n++) begin
      a = '0;
      b = '0;
      for (int d = 0; d < DIGITS; d++) begin
        a[4*d +: 4] = 4'($urandom_range(0, (n % 8 == 7) ? 15 : 9));
        b[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run_op("random", a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_add();
    test_invalid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Digit-serial BCD adder. It consumes two registered multi-digit BCD operands, as produced by the team's 4-bit operand register stage.
- Adds one decimal digit per clock, least-significant digit first, with a carry flip-flop between digits.
- Presents the BCD sum and carry-out in a held result register, with a start/busy/done handshake.
- Sits directly downstream of the operand registers and upstream of the display/result logic.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request to begin an addition; sampled only when not busy.
- a, input, 4*DIGITS, operand A, packed BCD, digit 0 in bits [3:0].
- b, input, 4*DIGITS, operand B, same packing.
- cin, input, 1, carry into digit 0.
- busy, output, 1, high while an addition is in progress.
- done, output, 1, one-cycle pulse when sum/cout are updated.
- sum, output, 4*DIGITS, BCD result, held between operations.
- cout, output, 1, decimal carry out of the most-significant digit, held.
- invalid, output, 1, set if any captured operand digit exceeded 9; held with the result.

Behaviour:
- Clocking: one clock (clk); synchronous active-high reset (rst). No asynchronous logic.
- Reset state: IDLE. busy=0, done=0, sum=0, cout=0, invalid=0; internal shift registers, carry and digit counter cleared.
- IDLE state:
  - start=1 captures a, b and cin into internal shift registers and the carry FF.
  - Computes the invalid flag from the captured digits into a pending flag.
  - Clears the digit counter and moves to ADD.
  - busy rises in the cycle after start.
- ADD state: each cycle processes the current low digit pair (da, db) with carry c:
  - s = da + db + c, 5-bit unsigned.
  - If s > 9: digit = (s + 6) mod 16 and c' = 1; else digit = s and c' = 0.
  - This rule applies unchanged to invalid digits >9 (defined, not X).
  - Shift the operand registers right by 4; shift the digit into the working-sum register from the MSD end.
  - After DIGITS cycles, go to DONE.
- DONE state, one cycle:
  - Working sum → sum, final carry → cout, pending flag → invalid.
  - done=1 and busy=0 in this cycle; return to IDLE.
- Latency: start high in cycle T → done high in cycle T+DIGITS+1. Throughput is one operation per DIGITS+2 cycles.
- start while busy (ADD) or in DONE is ignored and not queued. Operands may change freely after capture.
- sum, cout and invalid change only in the DONE cycle or on reset. They hold their values through the next operation until its done.
- rst has priority over all other activity, including mid-ADD:
  - Next cycle the block is IDLE with all outputs 0.
  - The partial result is discarded; no done pulse.
- DIGITS=1 is legal: one ADD cycle.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9, BCD_CORR=5'd6.
  - State enum {IDLE, ADD, DONE}.
  - A function flagging a digit >9.
- One natural sub-module: bcd_digit_adder, a combinational single-digit adder (da, db, cin → digit, cout) implementing the correction rule. It is reusable by the parallel adder path.
- The top level holds the FSM, the counter sized $clog2(DIGITS+1), the shift registers and the result registers.

Test Plan:
1. DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse at cycle T → done at T+5, sum=0x6912, cout=0, invalid=0, busy high T+1..T+4.
2. a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1 (ripple carry through all digits).
3. a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1. Then a second start with a=b=0, cin=0 → sum=0x0000, cout=0 (back-to-back operation, held values correct between).
4. Start 0x0005+0x0005; re-pulse start with different operands at T+2 and again at T+5 (the DONE cycle) → both re-pulses ignored, sum=0x0010, single done pulse.
5. rst asserted at T+2 during ADD → next cycle busy=0, done=0, sum=0, cout=0, invalid=0, no done pulse. A fresh start with 0x0042+0x0058 then gives sum=0x0100.
6. a=0x00A0, b=0x0000, cin=0 → invalid=1, sum=0x0100, cout=0. Next valid operation (0x0001+0x0001) clears invalid to 0 at its done.
